mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS main control unit: a Moore state machine driven by the instruction opcode.
- Generates the select lines for the datapath muxes (IorD, ALUSrcA, ALUSrcB, PCSrc, RegDst, MemtoReg).
- Generates the write enables for PC, IR, register file and memory, plus ALUOp for the ALU decoder.
- Sits directly upstream of every datapath mux instance and drives their s inputs.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word
- OP_SW, 6'b101011, store word
- OP_BEQ, 6'b000100, branch if equal
- OP_BNE, 6'b000101, branch if not equal
- OP_ADDI, 6'b001000, add immediate
- OP_J, 6'b000010, jump

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode, IR[31:26], from the instruction register
- zero  in  1  ALU zero flag
- iord  out  1  memory address mux select: 0 = PC, 1 = ALUOut
- alusrca  out  1  ALU A select: 0 = PC, 1 = reg A
- alusrcb  out  2  ALU B select: 0 = reg B, 1 = 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- pcsrc  out  2  PC mux select: 0 = ALU result, 1 = ALUOut, 2 = jump target
- regdst  out  1  write register select: 0 = rt, 1 = rd
- memtoreg  out  1  write data select: 0 = ALUOut, 1 = MDR
- irwrite  out  1  IR load enable
- memwrite  out  1  memory write enable
- regwrite  out  1  register file write enable
- pcen  out  1  PC load enable
- aluop  out  2  0 = add, 1 = sub, 2 = use funct
- state  out  4  current state encoding, for debug and bench

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-low.
- State register: 4 bits, updates on the rising clk edge. rst_n = 0 forces FETCH immediately, regardless of clk.
- State encoding:
  - FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
  - RTEX = 6, RTWB = 7, BEQEX = 8, ADDIEX = 9, ADDIWB = 10, JEX = 11, BNEEX = 12
  - Codes 13-15 are illegal.
- Transitions:
  - FETCH -> DECODE.
  - DECODE: LW/SW -> MEMADR; RTYPE -> RTEX; BEQ -> BEQEX; BNE -> BNEEX; ADDI -> ADDIEX; J -> JEX; any other op -> FETCH (executes as a NOP).
  - MEMADR: LW -> MEMRD; SW -> MEMWR. The op value is re-sampled here; IR is stable.
  - MEMRD -> MEMWB; RTEX -> RTWB; ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTWB, ADDIWB, BEQEX, BNEEX and JEX all -> FETCH.
  - Illegal codes -> FETCH on the next edge.
- Outputs are pure decode of the state register (Moore); zero enters only through pcen. Any output not listed for a state is 0.
  - FETCH: iord = 0, alusrca = 0, alusrcb = 1, aluop = 0, pcsrc = 0, irwrite = 1, pcen = 1.
  - DECODE: alusrca = 0, alusrcb = 3, aluop = 0 (precomputes the branch target into ALUOut).
  - MEMADR: alusrca = 1, alusrcb = 2, aluop = 0.
  - MEMRD: iord = 1.
  - MEMWB: regdst = 0, memtoreg = 1, regwrite = 1.
  - MEMWR: iord = 1, memwrite = 1.
  - RTEX: alusrca = 1, alusrcb = 0, aluop = 2.
  - RTWB: regdst = 1, memtoreg = 0, regwrite = 1.
  - BEQEX: alusrca = 1, alusrcb = 0, aluop = 1, pcsrc = 1, pcen = zero.
  - BNEEX: same as BEQEX except pcen = ~zero.
  - ADDIEX: alusrca = 1, alusrcb = 2, aluop = 0.
  - ADDIWB: regdst = 0, memtoreg = 0, regwrite = 1.
  - JEX: pcsrc = 2, pcen = 1.
- Reset values:
  - During reset and on the first cycle after release, all outputs hold FETCH values: alusrcb = 1, irwrite = 1, pcen = 1, all others 0, state = 0.
  - memwrite and regwrite are never 1 while rst_n = 0.
- Timing:
  - CPI: LW 5, SW 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3, unknown op 2.
  - Output glitch-freedom is not required. Outputs settle within the cycle after the state edge.
- Reset mid-instruction: the state is abandoned with no completing write. A MEMWR or RTWB state interrupted by rst_n drops its enable asynchronously.
- Simultaneous events: zero changing while in BEQEX/BNEEX propagates combinationally to pcen. The datapath samples pcen only at the clk edge.

Test Plan:
- Reset mid-RTWB: rst_n = 0 while state = 7 -> regwrite drops to 0 with no clk edge, state = 0. Release rst_n -> FETCH outputs: irwrite = 1, pcen = 1, alusrcb = 1.
- LW op = 6'h23: states 0 -> 1 -> 2 -> 3 -> 4 -> 0 over 5 edges. In state 4: regwrite = 1, memtoreg = 1, regdst = 0. In state 3: iord = 1.
- SW op = 6'h2B: states 0 -> 1 -> 2 -> 5 -> 0. memwrite = 1 only in state 5, with iord = 1. regwrite stays 0 throughout.
- BEQ op = 6'h04: zero = 1 in state 8 -> pcen = 1, pcsrc = 1, aluop = 1. Repeat with zero = 0 -> pcen = 0. BNE op = 6'h05 with zero = 0 -> pcen = 1, state 12.
- R-type op = 0 then ADDI op = 6'h08: R-type reaches RTEX aluop = 2, then RTWB regdst = 1. ADDI reaches ADDIEX alusrcb = 2, then ADDIWB regdst = 0, regwrite = 1.
- J op = 6'h02 -> state 11 with pcsrc = 2, pcen = 1, then 0. Unknown op = 6'h3F -> state sequence 0 -> 1 -> 0, with no regwrite or memwrite asserted.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control unit.
// A Moore machine sequenced by the instruction opcode. It drives the datapath
// mux selects, the write enables for PC/IR/register file/memory, and ALUOp.
module mc_ctrl_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_BNE   = 6'b000101,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       zero,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       regdst,
    output logic       memtoreg,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       pcen,
    output logic [1:0] aluop,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        RTWB   = 4'd7,
        BEQEX  = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JEX    = 4'd11,
        BNEEX  = 4'd12
    } state_t;

    state_t cur_state;
    state_t nxt_state;

    assign state = cur_state;

    // State register; reset returns to FETCH immediately, without a clock edge,
    // so any pending register/memory write enable drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state selection and Moore output decode; zero only reaches pcen.
    always_comb begin
        nxt_state = FETCH;
        iord      = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'd0;
        pcsrc     = 2'd0;
        regdst    = 1'b0;
        memtoreg  = 1'b0;
        irwrite   = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        pcen      = 1'b0;
        aluop     = 2'd0;
        case (cur_state)
            FETCH: begin
                alusrcb   = 2'd1;
                irwrite   = 1'b1;
                pcen      = 1'b1;
                nxt_state = DECODE;
            end
            DECODE: begin
                // Branch target (PC+4 + imm<<2) is precomputed into ALUOut here.
                alusrcb = 2'd3;
                if (op == OP_LW || op == OP_SW) nxt_state = MEMADR;
                else if (op == OP_RTYPE)        nxt_state = RTEX;
                else if (op == OP_BEQ)          nxt_state = BEQEX;
                else if (op == OP_BNE)          nxt_state = BNEEX;
                else if (op == OP_ADDI)         nxt_state = ADDIEX;
                else if (op == OP_J)            nxt_state = JEX;
                else                            nxt_state = FETCH;
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'd2;
                // IR is stable, so op can be looked at again to split load/store.
                if (op == OP_LW)      nxt_state = MEMRD;
                else if (op == OP_SW) nxt_state = MEMWR;
                else                  nxt_state = FETCH;
            end
            MEMRD: begin
                iord      = 1'b1;
                nxt_state = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTEX: begin
                alusrca   = 1'b1;
                aluop     = 2'd2;
                nxt_state = RTWB;
            end
            RTWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'd1;
                pcsrc   = 2'd1;
                pcen    = zero;
            end
            BNEEX: begin
                alusrca = 1'b1;
                aluop   = 2'd1;
                pcsrc   = 2'd1;
                pcen    = ~zero;
            end
            ADDIEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'd2;
                nxt_state = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JEX: begin
                pcsrc = 2'd2;
                pcen  = 1'b1;
            end
            default: begin
                nxt_state = FETCH;
            end
        endcase
    end

endmodule
